// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit slice of the sum is
// resolved per stage, with the group carry registered between stages.
module cla_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NG = WIDTH / GROUP;
  localparam int NB = GROUP / 4;
  localparam int NR = (NG > 1) ? (NG - 1) : 1;

  // Returns {block carry out, carry into bit 3, 4-bit sum}.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       bg;
    logic       bp;
    p  = x ^ y;
    g  = x & y;
    c1 = g[0] | (p[0] & c);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    bg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    bp = &p;
    return {bg | (bp & c), c3, p ^ {c3, c2, c1, c}};
  endfunction

  // Returns {group carry out, carry into the group MSB, GROUP-bit sum}.
  function automatic logic [GROUP+1:0] grp_add(input logic [GROUP-1:0] x, input logic [GROUP-1:0] y,
                                               input logic c);
    logic [GROUP-1:0] s;
    logic             cc;
    logic             cm;
    logic [5:0]       r;
    s  = {GROUP{1'b0}};
    cc = c;
    cm = 1'b0;
    for (int j = 0; j < NB; j++) begin
      r           = cla4(x[4*j +: 4], y[4*j +: 4], cc);
      s[4*j +: 4] = r[3:0];
      cm          = r[4];
      cc          = r[5];
    end
    return {cc, cm, s};
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic [WIDTH-1:0] w_a_in  [NG];
  logic [WIDTH-1:0] w_b_in  [NG];
  logic [WIDTH-1:0] w_s_in  [NG];
  logic [WIDTH-1:0] w_s_nxt [NG];
  logic             w_c_in  [NG];
  logic             w_c_nxt [NG];
  logic [GROUP+1:0] w_grp   [NG];
  logic             w_cm;

  logic             r_valid [NG];
  logic [WIDTH-1:0] r_sum   [NG];
  logic             r_c     [NG];
  logic [WIDTH-1:0] r_a     [NR];
  logic [WIDTH-1:0] r_b     [NR];
  logic             r_cm;
  logic             r_zero;
  logic             r_neg;

  assign w_adv = ~r_valid[NG-1] | out_ready;

  // Operand conditioning: subtract is a + ~b + 1; op 11 falls through as add.
  always_comb begin
    w_b_eff = b;
    w_c0    = 1'b0;
    case (op)
      2'b01:   begin
        w_b_eff = ~b;
        w_c0    = 1'b1;
      end
      2'b10:   w_c0 = cin;
      default: w_c0 = 1'b0;
    endcase
  end

  // Per-stage group addition; stage k consumes the registered state of stage k-1.
  always_comb begin
    w_a_in[0] = a;
    w_b_in[0] = w_b_eff;
    w_c_in[0] = w_c0;
    w_s_in[0] = {WIDTH{1'b0}};
    for (int k = 1; k < NG; k++) begin
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_c_in[k] = r_c[k-1];
      w_s_in[k] = r_sum[k-1];
    end
    for (int k = 0; k < NG; k++) begin
      w_grp[k]   = grp_add(w_a_in[k][k*GROUP +: GROUP], w_b_in[k][k*GROUP +: GROUP], w_c_in[k]);
      w_s_nxt[k] = w_s_in[k];
      w_s_nxt[k][k*GROUP +: GROUP] = w_grp[k][GROUP-1:0];
      w_c_nxt[k] = w_grp[k][GROUP+1];
    end
    w_cm = w_grp[NG-1][GROUP];
  end

  // Pipeline registers: every stage shifts together on advance, bubbles included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NG; k++) begin
        r_valid[k] <= 1'b0;
        r_sum[k]   <= {WIDTH{1'b0}};
        r_c[k]     <= 1'b0;
      end
      for (int k = 0; k < NR; k++) begin
        r_a[k] <= {WIDTH{1'b0}};
        r_b[k] <= {WIDTH{1'b0}};
      end
      r_cm   <= 1'b0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_adv) begin
      r_valid[0] <= in_valid;
      for (int k = 1; k < NG; k++) begin
        r_valid[k] <= r_valid[k-1];
      end
      for (int k = 0; k < NG; k++) begin
        r_sum[k] <= w_s_nxt[k];
        r_c[k]   <= w_c_nxt[k];
      end
      for (int k = 0; k < NG - 1; k++) begin
        r_a[k] <= w_a_in[k];
        r_b[k] <= w_b_in[k];
      end
      r_cm   <= w_cm;
      r_zero <= (w_s_nxt[NG-1] == {WIDTH{1'b0}});
      r_neg  <= w_s_nxt[NG-1][WIDTH-1];
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_valid[NG-1];
  assign sum       = r_sum[NG-1];
  assign carry_out = r_c[NG-1];
  assign overflow  = r_c[NG-1] ^ r_cm;
  assign zero      = r_zero;
  assign negative  = r_neg;

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Operand width is split into GROUP-bit lookahead groups. One group is resolved per pipeline stage; the carry is registered between stages.
- Supports add, subtract and add-with-carry-in.
- Produces carry, signed-overflow, zero and negative flags.
- Uses a valid/ready handshake with full backpressure, so it can sit between the register-read and writeback stages.

Parameters:
- WIDTH, 32: operand/result width; must be a multiple of GROUP.
- GROUP, 8: bits resolved per stage with internal 4-bit lookahead; must be a multiple of 4.
- NG, WIDTH/GROUP (derived, localparam): number of pipeline stages = latency in cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operands and op present
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  2  00 add, 01 sub (a-b), 10 add with cin, 11 reserved (treated as add)
- cin  in  1  carry-in, used only for op=10
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- carry_out  out  1  carry from MSB (for sub: 1 = no borrow)
- overflow  out  1  signed overflow
- zero  out  1  sum == 0
- negative  out  1  sum[WIDTH-1]

Behaviour:
- Reset (async, active-high): all stage valid bits, out_valid, sum and all flags go to 0 immediately. Pipeline contents are discarded. in_ready is 1 during and after reset.
- Operand conditioning, combinational at input:
  - b_eff = op==01 ? ~b : b.
  - c0 = op==01 ? 1 : (op==10 ? cin : 0).
- Stage k (0..NG-1):
  - Computes bits [k*GROUP +: GROUP] of a + b_eff + c_k using 4-bit lookahead blocks, with carries chained via group P/G.
  - Registers the partial sum, the carry c_{k+1}, the not-yet-used upper operand bits, and a valid bit.
  - Lower result bits travel with the token.
- Global advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - On adv, every stage register loads from its predecessor, including bubbles.
  - Stage 0 loads valid = in_valid & in_ready.
  - When adv = 0 all registers hold.
- Latency: a token accepted at edge t appears with out_valid=1 after edge t+NG-1 (NG cycles with no stall). Throughput is 1 result per cycle.
- Output values:
  - out_valid and sum are the final stage registers.
  - carry_out = c_NG.
  - overflow = c_NG XOR c_{NG-1,msb}, i.e. the carry into the MSB XOR the carry out of the MSB. The carry into the MSB is registered in the last stage.
  - zero and negative are computed at the final register from the registered sum. They are held stable while out_valid & ~out_ready.
- Output values with out_valid=0: sum and flags are don't-care to the consumer, but must not be X after reset.
- Stall: once out_valid=1, sum and flags are unchanged until the cycle out_ready=1. No token is lost or duplicated.
- Simultaneous accept and drain when full (out_valid=1, out_ready=1, in_valid=1): both occur in the same cycle.
- Reset asserted mid-operation: all in-flight tokens are dropped. No partial result is ever emitted.
- op=11 behaves exactly as op=00. cin is ignored except for op=10.
- Wrap-around: sum is modulo 2^WIDTH, and carry_out holds the lost bit.

Test Plan:
- Basic add, WIDTH=32, GROUP=8:
  - a=0x0000_0005, b=0x0000_0003, op=00 → after 4 cycles sum=0x0000_0008, carry_out=0, overflow=0, zero=0, negative=0.
- Full carry ripple across all groups:
  - a=0xFFFF_FFFF, b=0x0000_0001, op=00 → sum=0x0000_0000, carry_out=1, zero=1, overflow=0.
  - a=0x7FFF_FFFF, b=1 → sum=0x8000_0000, overflow=1, negative=1.
- Subtract and add-with-carry:
  - a=3, b=5, op=01 → sum=0xFFFF_FFFE, carry_out=0, negative=1.
  - a=5, b=5, op=01 → zero=1, carry_out=1.
  - a=1, b=1, op=10, cin=1 → sum=3.
- Backpressure: stream 8 back-to-back tokens (a=i, b=i) with out_ready low for cycles 5–9 → in_ready drops while stalled, outputs held stable, all 8 results 2i emitted in order, with no gaps once out_ready returns high.
- Reset mid-flight: accept 3 tokens, then assert rst for 1 cycle → out_valid=0 immediately and no stale result appears afterwards. A new token a=2, b=2 returns 4 after NG cycles.
- Parameter sweep: WIDTH=64, GROUP=16 and WIDTH=16, GROUP=4 with 10k random operands and ops, checked against a behavioural model for sum and all flags, with latency = NG.
